// File: rtl/vote_cast_controller.sv
// Vote cast controller: accepts a validated voter ID, collects one candidate
// press under a timeout, commits it to saturating tallies and gates readout.
module vote_cast_controller #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int ID_W     = 5,
    parameter int TIMEOUT  = 16,
    localparam int SEL_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic                valid_voter_id_status,
    input  logic [ID_W-1:0]     voter_id,
    input  logic [NUM_CAND-1:0] candidate_btn,
    input  logic [SEL_W-1:0]    result_sel,
    output logic                busy,
    output logic                vote_done,
    output logic                dup_voter,
    output logic                vote_timeout,
    output logic [CNT_W-1:0]    result_count,
    output logic [CNT_W-1:0]    total_votes
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VOTE, CAST, LOCKOUT} state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SEL_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   tally_q [NUM_CAND];
    logic [CNT_W-1:0]   tally_d [NUM_CAND];
    logic [CNT_W-1:0]   total_q, total_d;
    logic [2**ID_W-1:0] voted_q, voted_d;
    logic               done_q, done_d;
    logic               dup_q, dup_d;
    logic               tmo_q, tmo_d;
    logic               one_hot;
    logic [SEL_W-1:0]   btn_idx;
    logic               rd_en;

    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (candidate_btn[i]) btn_idx = SEL_W'(i);
        end
    end

    assign one_hot = (candidate_btn != '0) &&
                     ((candidate_btn & (candidate_btn - NUM_CAND'(1))) == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        id_d    = id_q;
        cand_d  = cand_q;
        tally_d = tally_q;
        total_d = total_q;
        voted_d = voted_q;
        done_d  = 1'b0;
        dup_d   = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mode && valid_voter_id_status) begin
                    id_d = voter_id;
                    if (voted_q[voter_id]) begin
                        dup_d = 1'b1;
                    end else begin
                        timer_d = '0;
                        state_d = WAIT_VOTE;
                    end
                end
            end
            WAIT_VOTE: begin
                // Abort beats a press, and a press beats expiry.
                if (!mode) begin
                    state_d = IDLE;
                end else if (one_hot) begin
                    cand_d  = btn_idx;
                    state_d = CAST;
                end else if (timer_q == TMR_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CAST: begin
                if (tally_q[cand_q] != '1)
                    tally_d[cand_q] = tally_q[cand_q] + CNT_W'(1);
                if (total_q != '1)
                    total_d = total_q + CNT_W'(1);
                voted_d[id_q] = 1'b1;
                done_d  = 1'b1;
                state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (candidate_btn == '0 && !valid_voter_id_status)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            id_q    <= '0;
            cand_q  <= '0;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
            total_q <= '0;
            voted_q <= '0;
            done_q  <= 1'b0;
            dup_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            id_q    <= id_d;
            cand_q  <= cand_d;
            tally_q <= tally_d;
            total_q <= total_d;
            voted_q <= voted_d;
            done_q  <= done_d;
            dup_q   <= dup_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign vote_done    = done_q;
    assign dup_voter    = dup_q;
    assign vote_timeout = tmo_q;

    // Tallies are only visible while idle in result mode.
    assign rd_en = !mode && (state_q == IDLE);

    always_comb begin
        result_count = '0;
        if (rd_en && int'(result_sel) < NUM_CAND)
            result_count = tally_q[result_sel];
    end

    assign total_votes = rd_en ? total_q : '0;

endmodule
